axi_rd_rr_mux: RTL and testbench

- Shares one AXI read path (AR/R) between NumSlvPorts requesters using round-robin arbitration on AR.
- Extends the AR ID with the winning port index and routes R beats back by the upper ID bits.
- Caps outstanding reads per port.
- Sits upstream of the channel delay/cut stages, feeding a single downstream read slave.

---
 rtl/axi_rd_rr_mux_if.sv | 57 +++++
 rtl/axi_rd_rr_mux.sv | 132 +++++++++++++
 tb/tb_axi_rd_rr_mux.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_rr_mux_if.sv
// AR/R bundle between the read requesters, the round-robin mux and the shared read slave.
// Master-port IDs carry the requester index above the slave-port ID bits.
interface axi_rd_rr_mux_if #(
  parameter int NumSlvPorts = 2,
  parameter int SlvIdWidth  = 4,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 32
);
  localparam int MstIdWidth = SlvIdWidth + $clog2(NumSlvPorts);

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
  } slv_ar_chan_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
  } mst_ar_chan_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic                  last;
  } slv_r_chan_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic                  last;
  } mst_r_chan_t;

  slv_ar_chan_t             slv_ar_i [NumSlvPorts];
  logic [NumSlvPorts-1:0]   slv_ar_valid_i;
  logic [NumSlvPorts-1:0]   slv_ar_ready_o;
  slv_r_chan_t              slv_r_o [NumSlvPorts];
  logic [NumSlvPorts-1:0]   slv_r_valid_o;
  logic [NumSlvPorts-1:0]   slv_r_ready_i;
  mst_ar_chan_t             mst_ar_o;
  logic                     mst_ar_valid_o;
  logic                     mst_ar_ready_i;
  mst_r_chan_t              mst_r_i;
  logic                     mst_r_valid_i;
  logic                     mst_r_ready_o;

  modport slave (
    input  slv_ar_i, slv_ar_valid_i, slv_r_ready_i, mst_ar_ready_i, mst_r_i, mst_r_valid_i,
    output slv_ar_ready_o, slv_r_o, slv_r_valid_o, mst_ar_o, mst_ar_valid_o, mst_r_ready_o
  );

  modport master (
    output slv_ar_i, slv_ar_valid_i, slv_r_ready_i, mst_ar_ready_i, mst_r_i, mst_r_valid_i,
    input  slv_ar_ready_o, slv_r_o, slv_r_valid_o, mst_ar_o, mst_ar_valid_o, mst_r_ready_o
  );
endinterface

// File: rtl/axi_rd_rr_mux.sv
// Round-robin AR mux with per-port outstanding-read caps; R beats routed back by the upper ID bits.
// Zero-latency combinational AR/R paths; a stalled AR grant is locked until it handshakes.
module axi_rd_rr_mux #(
  parameter int NumSlvPorts = 2,
  parameter int MaxTxns     = 4,
  parameter int SlvIdWidth  = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  axi_rd_rr_mux_if.slave bus,
  output logic           busy_o
);
  localparam int IdxW       = $clog2(NumSlvPorts);
  localparam int MstIdWidth = SlvIdWidth + IdxW;
  localparam int CntW       = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] CapVal  = CntW'(MaxTxns);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSlvPorts - 1);

  logic [IdxW-1:0]        rr_q;
  logic                   lock_q;
  logic [IdxW-1:0]        lock_idx_q;
  logic [CntW-1:0]        cnt_q [NumSlvPorts];

  logic [NumSlvPorts-1:0] eligible;
  logic                   grant_vld;
  logic [IdxW-1:0]        grant_idx;
  logic                   ar_hs;
  logic [NumSlvPorts-1:0] ar_inc;
  logic [IdxW-1:0]        r_idx;
  logic                   idx_ok;
  logic                   r_rdy;
  logic [NumSlvPorts-1:0] r_dec;
  logic [NumSlvPorts-1:0] cnt_nz;

  // A locked grant ignores eligibility so the payload stays stable until accepted.
  always_comb begin
    int cand;
    cand      = 0;
    eligible  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int p = 0; p < NumSlvPorts; p++)
      eligible[p] = bus.slv_ar_valid_i[p] && (cnt_q[p] < CapVal);
    if (lock_q) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      for (int i = 0; i < NumSlvPorts; i++) begin
        cand = (int'(rr_q) + i) % NumSlvPorts;
        if (!grant_vld && eligible[IdxW'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = IdxW'(cand);
        end
      end
    end
  end

  always_comb begin
    bus.mst_ar_o       = '0;
    bus.slv_ar_ready_o = '0;
    ar_inc             = '0;
    for (int p = 0; p < NumSlvPorts; p++) begin
      if (grant_idx == IdxW'(p)) begin
        bus.mst_ar_o.id   = {grant_idx, bus.slv_ar_i[p].id};
        bus.mst_ar_o.addr = bus.slv_ar_i[p].addr;
        bus.mst_ar_o.len  = bus.slv_ar_i[p].len;
        bus.slv_ar_ready_o[p] = grant_vld && bus.mst_ar_ready_i && !rst_i;
      end
    end
    bus.mst_ar_valid_o = grant_vld && !rst_i;
    ar_hs              = grant_vld && bus.mst_ar_ready_i;
    for (int p = 0; p < NumSlvPorts; p++)
      ar_inc[p] = ar_hs && (grant_idx == IdxW'(p));
  end

  // Out-of-range indices are swallowed (ready high, no slave valid).
  always_comb begin
    r_idx  = bus.mst_r_i.id[MstIdWidth-1:SlvIdWidth];
    idx_ok = {1'b0, r_idx} < (IdxW + 1)'(NumSlvPorts);
    r_rdy  = 1'b1;
    r_dec  = '0;
    bus.slv_r_valid_o = '0;
    for (int p = 0; p < NumSlvPorts; p++) begin
      bus.slv_r_o[p].id   = bus.mst_r_i.id[SlvIdWidth-1:0];
      bus.slv_r_o[p].data = bus.mst_r_i.data;
      bus.slv_r_o[p].last = bus.mst_r_i.last;
      if (r_idx == IdxW'(p)) begin
        bus.slv_r_valid_o[p] = bus.mst_r_valid_i && !rst_i;
        r_rdy                = bus.slv_r_ready_i[p];
      end
    end
    bus.mst_r_ready_o = r_rdy && !rst_i;
    for (int p = 0; p < NumSlvPorts; p++)
      r_dec[p] = bus.mst_r_valid_i && r_rdy && bus.mst_r_i.last && idx_ok && (r_idx == IdxW'(p));
  end

  always_comb begin
    cnt_nz = '0;
    for (int p = 0; p < NumSlvPorts; p++)
      cnt_nz[p] = (cnt_q[p] != '0);
    busy_o = (|cnt_nz) && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int p = 0; p < NumSlvPorts; p++)
        cnt_q[p] <= '0;
    end else begin
      if (ar_hs) begin
        lock_q <= 1'b0;
        rr_q   <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
      end else if (grant_vld) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end
      for (int p = 0; p < NumSlvPorts; p++) begin
        if (ar_inc[p] && !r_dec[p])
          cnt_q[p] <= cnt_q[p] + 1'b1;
        else if (r_dec[p] && !ar_inc[p])
          cnt_q[p] <= cnt_q[p] - 1'b1;
      end
    end
  end

  r_idx_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.mst_r_valid_i |-> idx_ok);
  cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_dec & ~cnt_nz) == '0);
endmodule

// File: tb/tb_axi_rd_rr_mux.sv
// Directed bench for axi_rd_rr_mux: stimulus pushes expected AR/R transfers, a negedge monitor pops and compares.
module tb_axi_rd_rr_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  axi_rd_rr_mux_if #(.NumSlvPorts(2), .SlvIdWidth(4)) bus ();

  axi_rd_rr_mux #(.NumSlvPorts(2), .MaxTxns(4), .SlvIdWidth(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus.slave),
    .busy_o (busy)
  );

  typedef struct { logic [4:0] id; logic [31:0] addr; } ar_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic last; } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q0[$];
  r_exp_t  r_q1[$];
  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_mis++;
    $display("FAIL %s: got transfer 0x%0h, expected none", name, act);
  endtask

  // Monitor: every handshake seen on an output must match the head of its queue.
  always @(negedge clk) begin
    ar_exp_t ea;
    r_exp_t  er;
    if (bus.mst_ar_valid_o && bus.mst_ar_ready_i) begin
      if (ar_q.size() == 0) unexpected("ar_unexpected", 32'(bus.mst_ar_o.id));
      else begin
        ea = ar_q.pop_front();
        chk("ar_id", 32'(bus.mst_ar_o.id), 32'(ea.id));
        chk("ar_addr", bus.mst_ar_o.addr, ea.addr);
        chk("ar_slv_ready", 32'(bus.slv_ar_ready_o), 32'(1) << ea.id[4]);
      end
    end
    if (bus.slv_r_valid_o[0] && bus.slv_r_ready_i[0]) begin
      if (r_q0.size() == 0) unexpected("r0_unexpected", bus.slv_r_o[0].data);
      else begin
        er = r_q0.pop_front();
        chk("r0_id", 32'(bus.slv_r_o[0].id), 32'(er.id));
        chk("r0_data", bus.slv_r_o[0].data, er.data);
        chk("r0_last", 32'(bus.slv_r_o[0].last), 32'(er.last));
      end
    end
    if (bus.slv_r_valid_o[1] && bus.slv_r_ready_i[1]) begin
      if (r_q1.size() == 0) unexpected("r1_unexpected", bus.slv_r_o[1].data);
      else begin
        er = r_q1.pop_front();
        chk("r1_id", 32'(bus.slv_r_o[1].id), 32'(er.id));
        chk("r1_data", bus.slv_r_o[1].data, er.data);
        chk("r1_last", 32'(bus.slv_r_o[1].last), 32'(er.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      bus.slv_ar_i[p].id   = '0;
      bus.slv_ar_i[p].addr = '0;
      bus.slv_ar_i[p].len  = '0;
    end
    bus.slv_ar_valid_i = '0;
    bus.slv_r_ready_i  = 2'b11;
    bus.mst_ar_ready_i = 1'b0;
    bus.mst_r_i        = '0;
    bus.mst_r_valid_i  = 1'b0;
  endtask

  task automatic set_ar(input int p, input logic [3:0] id, input logic [31:0] addr);
    bus.slv_ar_i[p].id   = id;
    bus.slv_ar_i[p].addr = addr;
    bus.slv_ar_i[p].len  = 8'd3;
    bus.slv_ar_valid_i[p] = 1'b1;
  endtask

  task automatic push_ar(input logic [4:0] id, input logic [31:0] addr);
    ar_exp_t e;
    e.id   = id;
    e.addr = addr;
    ar_q.push_back(e);
  endtask

  // One R beat, accepted at the next edge (slave ready is held high).
  task automatic send_r(input logic [4:0] id, input logic [31:0] data, input logic last);
    r_exp_t e;
    e.id   = id[3:0];
    e.data = data;
    e.last = last;
    if (id[4]) r_q1.push_back(e);
    else       r_q0.push_back(e);
    bus.mst_r_i.id    = id;
    bus.mst_r_i.data  = data;
    bus.mst_r_i.last  = last;
    bus.mst_r_valid_i = 1'b1;
    tick();
    bus.mst_r_valid_i = 1'b0;
  endtask

  task automatic reset_one();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    // Reset with every input asserted: outputs must stay quiet.
    rst = 1'b1;
    bus.slv_ar_valid_i = 2'b11;
    bus.mst_ar_ready_i = 1'b1;
    bus.mst_r_i.id     = 5'h03;
    bus.mst_r_i.last   = 1'b1;
    bus.mst_r_valid_i  = 1'b1;
    tick(); tick();
    chk("rst_mst_ar_valid", 32'(bus.mst_ar_valid_o), 0);
    chk("rst_slv_ar_ready", 32'(bus.slv_ar_ready_o), 0);
    chk("rst_slv_r_valid", 32'(bus.slv_r_valid_o), 0);
    chk("rst_mst_r_ready", 32'(bus.mst_r_ready_o), 0);
    chk("rst_busy", 32'(busy), 0);
    idle();
    rst = 1'b0;
    tick();

    // Basic path.
    push_ar(5'h03, 32'h100);
    set_ar(0, 4'h3, 32'h100);
    bus.mst_ar_ready_i = 1'b1;
    #1;
    chk("basic_ar_valid", 32'(bus.mst_ar_valid_o), 1);
    chk("basic_ar_id", 32'(bus.mst_ar_o.id), 32'h03);
    tick();
    bus.slv_ar_valid_i = '0;
    bus.mst_ar_ready_i = 1'b0;
    #1;
    chk("basic_busy_set", 32'(busy), 1);
    send_r(5'h03, 32'hAAAA, 1'b1);
    #1;
    chk("basic_busy_clr", 32'(busy), 0);

    // Round robin from rr=0: grants 0,1,0,1.
    reset_one();
    push_ar(5'h02, 32'h200); push_ar(5'h15, 32'h210);
    push_ar(5'h02, 32'h200); push_ar(5'h15, 32'h210);
    set_ar(0, 4'h2, 32'h200);
    set_ar(1, 4'h5, 32'h210);
    bus.mst_ar_ready_i = 1'b1;
    repeat (4) tick();
    bus.slv_ar_valid_i = '0;
    bus.mst_ar_ready_i = 1'b0;
    send_r(5'h02, 32'h20, 1'b1); send_r(5'h02, 32'h21, 1'b1);
    send_r(5'h15, 32'h22, 1'b1); send_r(5'h15, 32'h23, 1'b1);
    #1;
    chk("rr_busy_clr", 32'(busy), 0);

    // Lock: port1 stalls, port0 raising valid must not preempt.
    set_ar(1, 4'h7, 32'h300);
    #1;
    chk("lock_first_id", 32'(bus.mst_ar_o.id), 32'h17);
    tick();
    set_ar(0, 4'h1, 32'h400);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_hold_id", 32'(bus.mst_ar_o.id), 32'h17);
      chk("lock_hold_addr", bus.mst_ar_o.addr, 32'h300);
      chk("lock_hold_valid", 32'(bus.mst_ar_valid_o), 1);
      tick();
    end
    push_ar(5'h17, 32'h300);
    push_ar(5'h01, 32'h400);
    bus.mst_ar_ready_i = 1'b1;
    tick();
    bus.slv_ar_valid_i[1] = 1'b0;
    tick();
    bus.slv_ar_valid_i = '0;
    bus.mst_ar_ready_i = 1'b0;
    send_r(5'h17, 32'h30, 1'b1);
    send_r(5'h01, 32'h40, 1'b1);

    // Cap: four reads from port0 fill it; port1 still served; one R-last frees a slot.
    set_ar(0, 4'h4, 32'h500);
    bus.mst_ar_ready_i = 1'b1;
    repeat (4) push_ar(5'h04, 32'h500);
    repeat (4) tick();
    chk("cap_ar_valid", 32'(bus.mst_ar_valid_o), 0);
    chk("cap_slv_ready", 32'(bus.slv_ar_ready_o), 0);
    set_ar(1, 4'h9, 32'h600);
    push_ar(5'h19, 32'h600);
    #1;
    chk("cap_port1_ready", 32'(bus.slv_ar_ready_o), 32'b10);
    tick();
    bus.slv_ar_valid_i[1] = 1'b0;
    #1;
    chk("cap_still_blocked", 32'(bus.mst_ar_valid_o), 0);
    send_r(5'h04, 32'h50, 1'b1);
    push_ar(5'h04, 32'h500);
    #1;
    chk("cap_freed_ready", 32'(bus.slv_ar_ready_o), 32'b01);
    tick();
    bus.slv_ar_valid_i = '0;
    bus.mst_ar_ready_i = 1'b0;

    // Simultaneous AR and R-last on port0 at cnt0=2: exactly two more reads fit afterwards.
    send_r(5'h04, 32'h51, 1'b1);
    send_r(5'h04, 32'h52, 1'b1);
    set_ar(0, 4'h6, 32'h700);
    bus.mst_ar_ready_i = 1'b1;
    push_ar(5'h06, 32'h700);
    send_r(5'h04, 32'h53, 1'b1);
    push_ar(5'h06, 32'h700);
    push_ar(5'h06, 32'h700);
    tick(); tick();
    chk("simul_cap_reached", 32'(bus.mst_ar_valid_o), 0);
    bus.slv_ar_valid_i = '0;
    bus.mst_ar_ready_i = 1'b0;

    // Interleaved 4-beat bursts for both ports.
    for (int k = 0; k < 4; k++) begin
      send_r(5'h06, 32'hA0 + k, k == 3);
      send_r(5'h19, 32'hB0 + k, k == 3);
    end

    // Mid-operation reset with cnt0=3 and a lock held on port1.
    set_ar(1, 4'h2, 32'h800);
    #1;
    chk("mrst_pre_id", 32'(bus.mst_ar_o.id), 32'h12);
    tick();
    set_ar(0, 4'h5, 32'h900);
    #1;
    chk("mrst_lock_id", 32'(bus.mst_ar_o.id), 32'h12);
    rst = 1'b1;
    bus.mst_ar_ready_i = 1'b1;
    bus.mst_r_i.id     = 5'h06;
    bus.mst_r_i.last   = 1'b1;
    bus.mst_r_valid_i  = 1'b1;
    #1;
    chk("mrst_ar_valid", 32'(bus.mst_ar_valid_o), 0);
    chk("mrst_slv_ar_ready", 32'(bus.slv_ar_ready_o), 0);
    chk("mrst_slv_r_valid", 32'(bus.slv_r_valid_o), 0);
    chk("mrst_mst_r_ready", 32'(bus.mst_r_ready_o), 0);
    chk("mrst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    bus.mst_r_valid_i  = 1'b0;
    bus.mst_ar_ready_i = 1'b0;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_grant_id", 32'(bus.mst_ar_o.id), 32'h05);
    push_ar(5'h05, 32'h900);
    push_ar(5'h12, 32'h800);
    bus.mst_ar_ready_i = 1'b1;
    tick();
    bus.slv_ar_valid_i[0] = 1'b0;
    tick();
    bus.slv_ar_valid_i = '0;
    bus.mst_ar_ready_i = 1'b0;
    #1;
    chk("post_rst_busy_set", 32'(busy), 1);

    repeat (3) tick();
    chk("ar_queue_drained", 32'(ar_q.size()), 0);
    chk("r0_queue_drained", 32'(r_q0.size()), 0);
    chk("r1_queue_drained", 32'(r_q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
